// File: rtl/fnd_pkg.sv
// Shared constants and types for the 4-digit common-anode FND scan controller.
// Segment codes are active-low, bit order {dp,g,f,e,d,c,b,a}.
package fnd_pkg;

  localparam int NUM_DIGITS = 4;

  localparam logic [7:0] SEG_OFF = 8'hFF;
  localparam logic [3:0] COM_OFF = 4'b1111;

  // Entry n is the pattern for hex digit n (entry 0 is the rightmost byte).
  localparam logic [15:0][7:0] HEX_SEG = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  typedef enum logic {
    ST_BLANK,
    ST_DRIVE
  } scan_state_e;

  typedef struct packed {
    logic [15:0] value;
    logic [3:0]  dp;
    logic        blank_lz;
  } disp_data_t;

  // Bit k set when digit k is a leading zero to suppress; digit 0 always shows.
  function automatic logic [NUM_DIGITS-1:0] lz_mask(input logic [15:0] value,
                                                    input logic        en);
    logic [NUM_DIGITS-1:0] mask;
    logic                  all_zero;
    mask     = '0;
    all_zero = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      all_zero = all_zero & (value[4*k +: 4] == 4'h0);
      mask[k]  = en & all_zero;
    end
    return mask;
  endfunction

endpackage

// File: rtl/fnd_if.sv
// Load/ack handshake between the application logic and the FND scan controller.
interface fnd_if;
  import fnd_pkg::*;

  logic [15:0] value;
  logic [3:0]  dp;
  logic        blank_lz;
  logic        load;
  logic        ack;

  modport master (output value, output dp, output blank_lz, output load, input ack);
  modport slave  (input value, input dp, input blank_lz, input load, output ack);

endinterface

// File: rtl/fnd_hex_decoder.sv
// Combinational hex nibble to active-low 7-segment pattern, dp folded into bit 7.
module fnd_hex_decoder
  import fnd_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       dp,
  output logic [7:0] seg
);

  logic [7:0] hex_code;

  assign hex_code = HEX_SEG[nibble];
  assign seg      = {~dp, hex_code[6:0]};

endmodule

// File: rtl/fnd_scan_controller.sv
// Time-multiplexed scan of a 4-digit FND with per-slot dead time and
// frame-aligned latching of new display data via a load/ack handshake.
module fnd_scan_controller
  import fnd_pkg::*;
#(
  parameter int unsigned CLK_DIV   = 100000,
  parameter int unsigned BLANK_CYC = 1000
) (
  input  logic       i_clk,
  input  logic       i_reset,
  fnd_if.slave       bus,
  output logic [3:0] o_com,
  output logic [7:0] o_seg
);

  localparam int unsigned     CNT_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LIM = CNT_W'(BLANK_CYC);
  localparam scan_state_e      ST_RESET  = (BLANK_CYC > 0) ? ST_BLANK : ST_DRIVE;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  scan_state_e      state_q, state_d;

  disp_data_t       shadow_q, shadow_d;
  disp_data_t       pend_q;
  logic             pend_valid_q, pend_valid_d;

  logic [3:0]       com_d;
  logic [7:0]       seg_d;
  logic             ack_d;
  logic             frame_end;

  logic [3:0]       cur_nibble;
  logic             cur_dp;
  logic [7:0]       dec_seg;
  logic [3:0]       lz;

  assign cur_nibble = shadow_q.value[{idx_q, 2'b00} +: 4];
  assign cur_dp     = shadow_q.dp[idx_q];
  assign lz         = lz_mask(shadow_q.value, shadow_q.blank_lz);
  assign frame_end  = (cnt_q == CNT_MAX) && (idx_q == 2'd3);

  fnd_hex_decoder u_dec (
    .nibble (cur_nibble),
    .dp     (cur_dp),
    .seg    (dec_seg)
  );

  // NOTE: every signal gets a default before any branch so no latch is inferred.
  always_comb begin
    cnt_d   = cnt_q + 1'b1;
    idx_d   = idx_q;
    if (cnt_q == CNT_MAX) begin
      cnt_d = '0;
      idx_d = idx_q + 2'd1;
    end
    // Phase tracks the counter value the next cycle will hold.
    state_d = ((BLANK_CYC > 0) && (cnt_d < BLANK_LIM)) ? ST_BLANK : ST_DRIVE;
  end

  always_comb begin
    com_d = COM_OFF;
    seg_d = SEG_OFF;
    if (state_q == ST_DRIVE) begin
      com_d = ~(4'b0001 << idx_q);
      seg_d = lz[idx_q] ? {~cur_dp, 7'h7F} : dec_seg;
    end
  end

  // A load arriving on the boundary cycle stays pending for the following frame.
  always_comb begin
    shadow_d     = shadow_q;
    pend_valid_d = pend_valid_q;
    ack_d        = 1'b0;
    if (frame_end && pend_valid_q) begin
      shadow_d     = pend_q;
      pend_valid_d = 1'b0;
      ack_d        = 1'b1;
    end
    if (bus.load) begin
      pend_valid_d = 1'b1;
    end
  end

  // NOTE: state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      state_q      <= ST_RESET;
      o_com        <= COM_OFF;
      o_seg        <= SEG_OFF;
      bus.ack      <= 1'b0;
      shadow_q     <= '0;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      state_q      <= state_d;
      o_com        <= com_d;
      o_seg        <= seg_d;
      bus.ack      <= ack_d;
      shadow_q     <= shadow_d;
      pend_valid_q <= pend_valid_d;
      if (bus.load) begin
        pend_q <= {bus.value, bus.dp, bus.blank_lz};
      end
    end
  end

endmodule

// File: doc/fnd_scan_controller.md
Name: fnd_scan_controller

Overview:
Time-multiplexed scan controller for a 4-digit common-anode FND (7-segment) display. It owns the digit-select counter and divides the system clock into per-digit slots, inserting anti-ghosting dead time at each slot start. Each nibble is decoded to an active-low segment pattern. A load/ack handshake latches new display data only at frame boundaries, so a frame never shows a mix of old and new digits. It sits between the application logic, which produces the 16-bit value, and the board-level FND pins.

Parameters:
- CLK_DIV, 100000, clock cycles per digit slot; 1 kHz digit rate at 100 MHz. Legal when CLK_DIV >= BLANK_CYC+2.
- BLANK_CYC, 1000, cycles at the start of each slot during which all digits are off (dead time).

Ports:
- i_clk  input  1  system clock
- i_reset  input  1  synchronous, active-high reset
- i_value  input  16  display value, 4 hex nibbles; nibble k maps to digit k (k=0 is rightmost)
- i_dp  input  4  decimal-point enable per digit, active-high
- i_blank_lz  input  1  leading-zero blanking enable
- i_load  input  1  request to latch i_value/i_dp/i_blank_lz
- o_ack  output  1  one-cycle pulse: pending data now displayed
- o_com  output  4  digit enables, active-low; bit k selects digit k
- o_seg  output  8  segments, active-low, {dp,g,f,e,d,c,b,a}

Behaviour:
- Clocking and reset: one clock, i_clk. Reset is synchronous and active-high on i_reset. Every register updates only on posedge i_clk.
- Reset values:
  - o_com=4'b1111, o_seg=8'hFF, o_ack=0
  - slot counter cnt=0, digit index idx=0
  - shadow value=0, shadow dp=0, shadow blank_lz=0
  - pending flag=0
- Reset mid-operation: on the next edge everything returns to the reset values; any pending load is discarded and no ack is issued.
- Slot counter: cnt counts 0..CLK_DIV-1 and wraps to 0. On wrap, idx increments modulo 4 (0,1,2,3,0).
- Frame boundary: the cycle in which cnt==CLK_DIV-1 and idx==3.
- State machine (per slot):
  - BLANK when cnt < BLANK_CYC; DRIVE otherwise.
  - BLANK: next o_com=4'b1111, next o_seg=8'hFF.
  - DRIVE: next o_com has only bit idx low; next o_seg = decode(shadow nibble idx), with dp bit = ~shadow_dp[idx].
  - With BLANK_CYC=0, BLANK never occurs.
- Output latency: o_com and o_seg are registered, one cycle after the internal cnt/idx state.
- Decode: active-low hex codes:
  - 0 C0, 1 F9, 2 A4, 3 B0, 4 99, 5 92, 6 82, 7 F8
  - 8 80, 9 90, A 88, b 83, C C6, d A1, E 86, F 8E
  - The dp bit (bit 7) overrides the decoded value's bit 7.
- Leading-zero blanking:
  - Digit k (k>=1) is blanked (o_seg=8'hFF, o_com still asserted for that slot) when shadow blank_lz=1 and nibbles k..3 are all zero.
  - Digit 0 is never blanked.
  - A set dp on a blanked digit still lights the dp segment only (o_seg=8'h7F).
- Load handshake:
  - When i_load=1: pending regs <= {i_value, i_dp, i_blank_lz} and the pending flag is set. The latest load wins.
  - At a frame boundary with the pending flag set: shadow <= pending, flag cleared, o_ack=1 on the following cycle for exactly one cycle.
- Simultaneous load and boundary: a load in the same cycle as a frame boundary does not reach the shadow at that boundary. The old pending data, if any, transfers and ack pulses. The new data becomes pending and is applied at the next frame boundary with its own ack.
- Without a load, the shadow holds indefinitely. i_value changes without i_load have no effect.

Decomposition:
- Package fnd_pkg:
  - 16-entry hex-to-segment constant table
  - SEG_OFF=8'hFF, COM_OFF=4'b1111
  - digit count constant NUM_DIGITS=4
- Sub-module fnd_hex_decoder: combinational, 4-bit nibble plus dp in, 8-bit active-low segments out.
- The scan state machine, prescaler, and load/ack logic stay in fnd_scan_controller.

Test Plan:
All scenarios use CLK_DIV=8, BLANK_CYC=2.
1. Reset: hold i_reset for 3 cycles, then release.
   -> o_com=1111, o_seg=FF, o_ack=0 during reset.
   -> First DRIVE of digit 0 shows o_com=1110, o_seg=C0.
2. Scan order: load 16'h1234 and run 2 frames.
   -> Per-slot DRIVE sequence o_com/o_seg: 1110/99, 1101/B0, 1011/A4, 0111/F9.
   -> Each slot is preceded by exactly 2 cycles of 1111/FF.
3. Frame-boundary load: assert i_load with 16'hABCD mid-frame while 16'h1234 is shown.
   -> Digits 1..3 of the current frame still show 1234.
   -> o_ack pulses one cycle after the boundary.
   -> The next frame shows D,C,b,A (A1, C6, 83, 88).
4. Leading zeros: load 16'h0007 with blank_lz=1 and i_dp=4'b0100.
   -> digit0 F8; digit1 FF; digit2 7F; digit3 FF.
   -> With blank_lz=0: digit0 F8, digit1 C0, digit2 40, digit3 C0.
5. Collision: pend 16'h1111, then assert i_load with 16'h2222 in the boundary cycle.
   -> First ack, frame shows 1111.
   -> Second ack after the next boundary, frame shows 2222.
6. Reset mid-slot with a load pending.
   -> Outputs return to FF/1111 the next cycle.
   -> No o_ack is issued.
   -> The display shows 0000 (digit 0 = C0).
